// File: rtl/reg_wb_queue_pkg.sv
// rtl/reg_wb_queue_pkg.sv - shared widths, register-file constants and enable decode for the writeback queue
package reg_wb_queue_pkg;

    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;
    localparam int REG_COUNT = 32;
    localparam logic [AW_DEF-1:0] ZERO_REG = '0;

    // Register 0 is hardwired, so its enable bit can never be produced.
    function automatic logic [REG_COUNT-1:0] onehot(input logic [AW_DEF-1:0] addr);
        logic [REG_COUNT-1:0] v;
        v = '0;
        if (addr != ZERO_REG) v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wbq_fifo_mem.sv
// rtl/wbq_fifo_mem.sv - writeback queue storage with per-entry valid and full parallel read-out
module wbq_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int IW    = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                Clk,
    input  logic                Clrn,
    input  logic                i_wr_en,
    input  logic [IW-1:0]       i_wr_idx,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [DW-1:0]       i_wr_data,
    input  logic                i_clr_en,
    input  logic [IW-1:0]       i_clr_idx,
    output logic [DEPTH-1:0]    o_valid,
    output logic [DEPTH*AW-1:0] o_addr,
    output logic [DEPTH*DW-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_valid <= '0;
        end else begin
            if (i_clr_en) r_valid[i_clr_idx] <= 1'b0;
            if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
        end
    end

    // Payload needs no reset: nothing reads it unless the valid bit is set.
    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_addr[i_wr_idx] <= i_wr_addr;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_valid = r_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_out
        assign o_addr[g*AW +: AW] = r_addr[g];
        assign o_data[g*DW +: DW] = r_data[g];
    end

endmodule

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - writeback FIFO feeding the register array, with pending bitmap and youngest-value forwarding
module reg_wb_queue
    import reg_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [AW-1:0]     wb_addr,
    input  logic [DW-1:0]     wb_data,
    input  logic              drain_en,
    output logic [DW-1:0]     D,
    output logic [2**AW-1:0]  En,
    output logic [2**AW-1:0]  pend,
    input  logic [AW-1:0]     fwd_addr,
    output logic              fwd_hit,
    output logic [DW-1:0]     fwd_data
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int NR = 2**AW;

    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [DW-1:0]       r_D;
    logic [NR-1:0]       r_En;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [DEPTH-1:0]    w_valid;
    logic [DEPTH*AW-1:0] w_mem_addr;
    logic [DEPTH*DW-1:0] w_mem_data;
    logic [AW-1:0]       w_head_addr;
    logic [DW-1:0]       w_head_data;
    logic [NR-1:0]       w_pend;
    logic                w_hit;
    logic [DW-1:0]       w_fd;
    logic [IW-1:0]       w_idx;

    assign w_full   = (r_wr_ptr ^ r_rd_ptr) == {1'b1, {IW{1'b0}}};
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign wb_ready = ~w_full;
    // Writes to the zero register complete the handshake but are dropped here.
    assign w_push   = wb_valid & ~w_full & (wb_addr != ZERO_REG);
    assign w_pop    = drain_en & ~w_empty;

    assign w_head_addr = w_mem_addr[r_rd_ptr[IW-1:0]*AW +: AW];
    assign w_head_data = w_mem_data[r_rd_ptr[IW-1:0]*DW +: DW];

    wbq_fifo_mem #(
        .DEPTH (DEPTH),
        .IW    (IW),
        .AW    (AW),
        .DW    (DW)
    ) u_mem (
        .Clk       (Clk),
        .Clrn      (Clrn),
        .i_wr_en   (w_push),
        .i_wr_idx  (r_wr_ptr[IW-1:0]),
        .i_wr_addr (wb_addr),
        .i_wr_data (wb_data),
        .i_clr_en  (w_pop),
        .i_clr_idx (r_rd_ptr[IW-1:0]),
        .o_valid   (w_valid),
        .o_addr    (w_mem_addr),
        .o_data    (w_mem_data)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_D      <= '0;
            r_En     <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_D      <= w_head_data;
                r_En     <= onehot(w_head_addr);
            end else begin
                r_En     <= '0;
            end
        end
    end

    always_comb begin
        w_pend = r_En;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) w_pend = w_pend | onehot(w_mem_addr[i*AW +: AW]);
        end
    end

    // Walk oldest to newest so the youngest matching entry overrides; the in-flight stage is older than any queued entry.
    always_comb begin
        w_hit = 1'b0;
        w_fd  = '0;
        w_idx = '0;
        if (r_En[fwd_addr]) begin
            w_hit = 1'b1;
            w_fd  = r_D;
        end
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr[IW-1:0] + IW'(k);
            if (w_valid[w_idx] && (w_mem_addr[w_idx*AW +: AW] == fwd_addr)) begin
                w_hit = 1'b1;
                w_fd  = w_mem_data[w_idx*DW +: DW];
            end
        end
        if (fwd_addr == ZERO_REG) begin
            w_hit = 1'b0;
            w_fd  = '0;
        end
    end

    assign D        = r_D;
    assign En       = r_En;
    assign pend     = w_pend;
    assign fwd_hit  = w_hit;
    assign fwd_data = w_fd;

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - randomized scoreboard bench for reg_wb_queue against a queue-level reference model
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  ad;
        logic [31:0] dd;
    } ent_t;

    logic        Clk;
    logic        Clrn;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        drain_en;
    logic [31:0] D;
    logic [31:0] En;
    logic [31:0] pend;
    logic [4:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    reg_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .drain_en (drain_en),
        .D        (D),
        .En       (En),
        .pend     (pend),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          total = 0;
    int          bad   = 0;
    bit          mon_on = 1'b0;

    ent_t        mq[$];
    ent_t        sb[$];
    bit          inf_v = 1'b0;
    logic [4:0]  inf_a = '0;
    logic [31:0] inf_d = '0;
    logic [31:0] d_last = '0;

    logic [31:0] m_pend;
    bit          m_hit;
    logic [31:0] m_fd;
    ent_t        m_e;
    bit          acc;

    function automatic logic [31:0] oh(input logic [4:0] a);
        logic [31:0] one;
        one = 32'h1;
        return (a == 5'd0) ? 32'h0 : (one << a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the reference model across the edge.
    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit de, input logic [4:0] fa, output bit ok);
        bit drn;
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        drain_en = de;
        fwd_addr = fa;
        @(posedge Clk);
        ok  = v && (mq.size() < DEPTH);
        drn = de && (mq.size() != 0);
        if (drn) begin
            inf_v  = 1'b1;
            inf_a  = mq[0].ad;
            inf_d  = mq[0].dd;
            d_last = mq[0].dd;
            void'(mq.pop_front());
        end else begin
            inf_v = 1'b0;
        end
        if (ok && a != 5'd0) begin
            mq.push_back('{a, d});
            sb.push_back('{a, d});
        end
        #2;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input bit de, input logic [4:0] fa);
        bit ok;
        int n;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            step(1'b1, a, d, de, fa, ok);
            n++;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_timeout: got not-accepted want accepted addr %0d", a);
        end
    endtask

    task automatic idle(input int n, input bit de, input logic [4:0] fa);
        bit ok;
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, de, fa, ok);
    endtask

    // Monitor: compares DUT outputs to the model each falling edge and pops the scoreboard on every En pulse.
    initial begin
        forever begin
            @(negedge Clk);
            if (Clrn && mon_on) begin
                chk("ready", {31'b0, wb_ready}, {31'b0, mq.size() < DEPTH});
                m_pend = inf_v ? oh(inf_a) : 32'h0;
                foreach (mq[i]) m_pend = m_pend | oh(mq[i].ad);
                chk("pend", pend, m_pend);
                m_hit = 1'b0;
                m_fd  = 32'h0;
                if (fwd_addr != 5'd0) begin
                    if (inf_v && inf_a == fwd_addr) begin
                        m_hit = 1'b1;
                        m_fd  = inf_d;
                    end
                    foreach (mq[i]) begin
                        if (mq[i].ad == fwd_addr) begin
                            m_hit = 1'b1;
                            m_fd  = mq[i].dd;
                        end
                    end
                end
                chk("fwd_hit", {31'b0, fwd_hit}, {31'b0, m_hit});
                chk("fwd_data", fwd_data, m_fd);
                chk("en", En, inf_v ? oh(inf_a) : 32'h0);
                chk("d_hold", D, d_last);
                if (En != 32'h0) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL sb_extra: got En %h want no pulse", En);
                    end else begin
                        m_e = sb.pop_front();
                        chk("sb_en", En, oh(m_e.ad));
                        chk("sb_d", D, m_e.dd);
                    end
                end
            end
        end
    end

    initial begin
        Clrn     = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        drain_en = 1'b0;
        fwd_addr = '0;
        repeat (2) @(posedge Clk);
        #2;
        chk("rst_ready", {31'b0, wb_ready}, 32'h1);
        chk("rst_pend", pend, 32'h0);
        chk("rst_en", En, 32'h0);
        chk("rst_d", D, 32'h0);
        chk("rst_hit", {31'b0, fwd_hit}, 32'h0);
        chk("rst_fd", fwd_data, 32'h0);
        Clrn   = 1'b1;
        mon_on = 1'b1;

        // single write
        step(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, acc);
        chk("t1_pend5", pend, 32'h0000_0020);
        idle(1, 1'b1, 5'd5);
        chk("t1_en", En, 32'h0000_0020);
        chk("t1_d", D, 32'h1234_5678);
        idle(1, 1'b1, 5'd5);
        chk("t1_en_off", En, 32'h0);
        chk("t1_pend_off", pend, 32'h0);

        // fill and back-pressure
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i), 1'b0, 5'd3);
        chk("fill_ready", {31'b0, wb_ready}, 32'h0);
        step(1'b1, 5'd5, 32'h555, 1'b0, 5'd3, acc);
        chk("fill_held", {31'b0, acc}, 32'h0);
        step(1'b1, 5'd5, 32'h555, 1'b1, 5'd3, acc);
        chk("fill_held_drain", {31'b0, acc}, 32'h0);
        chk("fill_en0", En, 32'h2);
        step(1'b1, 5'd5, 32'h555, 1'b1, 5'd3, acc);
        chk("fill_acc5", {31'b0, acc}, 32'h1);
        chk("fill_en1", En, 32'h4);
        idle(6, 1'b1, 5'd5);

        // youngest forwarding
        push(5'd7, 32'hAAAA, 1'b0, 5'd7);
        push(5'd7, 32'hBBBB, 1'b0, 5'd7);
        chk("fwd_young", fwd_data, 32'hBBBB);
        idle(1, 1'b1, 5'd7);
        chk("fwd_after1", fwd_data, 32'hBBBB);
        idle(3, 1'b1, 5'd7);
        chk("fwd_gone", {31'b0, fwd_hit}, 32'h0);

        // zero register
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, acc);
        chk("zero_acc", {31'b0, acc}, 32'h1);
        chk("zero_pend", pend, 32'h0);
        idle(2, 1'b1, 5'd0);

        // back-to-back pushes with continuous drain
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(0, 31)), acc);
            chk("bb_acc", {31'b0, acc}, 32'h1);
            chk("bb_ready", {31'b0, wb_ready}, 32'h1);
        end
        idle(3, 1'b1, 5'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), acc);
        end
        idle(8, 1'b1, 5'd0);

        // reset mid-operation
        push(5'd9, 32'h9, 1'b0, 5'd10);
        push(5'd10, 32'hA, 1'b0, 5'd10);
        push(5'd11, 32'hB, 1'b0, 5'd10);
        idle(1, 1'b1, 5'd10);
        chk("mid_en_pre", En, 32'h0000_0200);
        Clrn = 1'b0;
        #1;
        chk("mid_en", En, 32'h0);
        chk("mid_pend", pend, 32'h0);
        chk("mid_hit", {31'b0, fwd_hit}, 32'h0);
        chk("mid_d", D, 32'h0);
        mq.delete();
        sb.delete();
        inf_v  = 1'b0;
        d_last = 32'h0;
        #1;
        Clrn = 1'b1;
        idle(5, 1'b1, 5'd10);

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Writeback buffer directly upstream of the 32x32 register array.
- Accepts writeback requests (address, data) over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drains one entry per cycle into the array's shared data bus D and one-hot enable En.
- Exposes a pending-write bitmap and a youngest-value forwarding lookup so readers see not-yet-committed results.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2
AW, 5, register address width
DW, 32, data width

Ports:
Clk  input  1  clock; all state updates on rising edge
Clrn  input  1  asynchronous active-low reset
wb_valid  input  1  writeback request valid
wb_ready  output  1  queue can accept; equals not-full
wb_addr  input  AW  destination register
wb_data  input  DW  writeback value
drain_en  input  1  array may accept a write this cycle
D  output  DW  write data to register array (registered)
En  output  2^AW  one-hot write enable to register array (registered); bit 0 always 0
pend  output  2^AW  bit r set while any queued or in-flight write targets r
fwd_addr  input  AW  forwarding lookup address
fwd_hit  output  1  a pending write to fwd_addr exists
fwd_data  output  DW  value of the youngest pending write to fwd_addr

Behaviour:
- Reset (Clrn low, asynchronous): wr_ptr=rd_ptr=0, all entries invalid, D=0, En=0. Outputs in that state: wb_ready=1, pend=0, fwd_hit=0, fwd_data=0. Reset mid-operation discards queued and in-flight writes; no En pulse is produced during or after reset.
- Pointers are log2(DEPTH)+1 bits wide. The MSB distinguishes full from empty; wrap-around is natural modulo 2*DEPTH.
- full = (wr_ptr^rd_ptr) == {1,0...}; empty = wr_ptr==rd_ptr.
- Accept: wb_valid & wb_ready at edge.
  - wb_addr != 0: entry written at wr_ptr, wr_ptr++.
  - wb_addr == 0: handshake completes, nothing enqueued, no pointer change.
- wb_ready = !full. It is combinational from registered state only and never depends on wb_valid.
- Drain: at edge, if drain_en & !empty, then D <= head data, En <= onehot(head addr), rd_ptr++. Otherwise En <= 0 and D holds its previous value.
- En is nonzero for exactly one cycle per drained entry.
- Latency: request accepted at edge N; earliest En pulse is visible after edge N+1; the array captures at edge N+2. An incoming request never bypasses the queue.
- Simultaneous accept and drain in the same cycle is allowed; occupancy is unchanged.
  - When full, wb_ready=0 blocks accept even if a drain occurs that cycle. wb_ready rises the cycle after the drain.
- Ordering: strict FIFO. Multiple entries to the same register commit oldest-first.
- pend: OR of onehot(addr) over valid queue entries and over the in-flight En register. Purely combinational from state.
- Forwarding priority, youngest first:
  1. Queue entries, newest to oldest from wr_ptr-1 back to rd_ptr.
  2. The in-flight stage (D/En targeting fwd_addr).
  3. fwd_addr==0 always gives hit=0, data=0.
  4. On a miss, fwd_data=0.
- An entry written on the current edge is not visible to pend/fwd until after that edge.

Decomposition:
- Shared package: AW/DW defaults, REG_COUNT=32, a ZERO_REG=0 constant, and an onehot decode function (addr -> 2^AW vector with bit 0 forced low).
- One natural sub-module, wbq_fifo_mem: DEPTH x (AW+DW) storage with per-entry valid, write port, and parallel read-out of all entries for pend/forward search.
- Control, drain register and forwarding mux stay in reg_wb_queue.

Test Plan:
- Reset then single write: addr=5, data=0x1234_5678, drain_en=1.
  - pend[5]=1 after edge 1.
  - En=0x0000_0020 and D=0x1234_5678 for exactly one cycle after edge 2.
  - pend=0 after edge 3.
- Fill: drain_en=0, push addr 1,2,3,4.
  - wb_ready=0 after the 4th accept; a 5th request is held.
  - drain_en=1 gives En pulses 0x2, 0x4, 0x8, 0x10 on consecutive cycles.
  - The 5th request is accepted the cycle wb_ready returns to 1.
- Forward youngest: drain_en=0, push (7, 0xAAAA), (7, 0xBBBB), fwd_addr=7.
  - fwd_hit=1, fwd_data=0xBBBB.
  - After draining one entry, fwd_data remains 0xBBBB.
  - After both commit, fwd_hit=0.
- Zero register: push addr=0 data=0xFFFF_FFFF.
  - Handshake completes, occupancy stays 0, En stays 0, pend=0.
  - fwd_addr=0 gives hit=0.
- Wrap-around and concurrency: run 20 back-to-back pushes with drain_en=1 every cycle.
  - Occupancy stays ≤1 and wb_ready stays 1 throughout.
  - En sequence matches the push order exactly.
- Reset mid-operation: 3 entries queued, pulse Clrn low between edges.
  - En=0 and pend=0 immediately.
  - No En pulse follows after Clrn returns high.
